// File: rtl/image_invert_accelerator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : image_invert_accelerator
//  Description : Memory-initiator accelerator that streams a 352x288 8-bit
//                greyscale image (four pixels per 32-bit word) out of a
//                single-port memory, writes the per-pixel inverse
//                (255 - p) into a second region, then raises finish.
//  Revision    : 1.0  initial release
// ============================================================================
module image_invert_accelerator #(
    parameter int WORDS    = 25344,
    parameter int OUT_BASE = 25344
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        finish,
    output logic        en,
    output logic        we,
    output logic [15:0] addr,
    output logic [31:0] dataW,
    input  logic [31:0] dataR
);

    // State encoding
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [15:0] c_LAST_IDX = 16'(WORDS - 1);
    localparam logic [15:0] c_OUT_BASE = 16'(OUT_BASE);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [15:0] r_idx;
    logic [15:0] w_idx_next;

    // State and word counter; reset acts immediately so the Moore-decoded
    // memory strobes drop without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Next-state logic and Moore output decode (outputs never look at start).
    // The memory registers its read data, so a word read in READ is on dataR
    // during the following WRITE cycle, where it is inverted and stored.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        finish       = 1'b0;
        en           = 1'b0;
        we           = 1'b0;
        addr         = '0;
        dataW        = '0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_next = c_READ;
                    w_idx_next   = '0;
                end
            end
            c_READ: begin
                en           = 1'b1;
                addr         = r_idx;
                w_state_next = c_WRITE;
            end
            c_WRITE: begin
                en    = 1'b1;
                we    = 1'b1;
                addr  = r_idx + c_OUT_BASE;
                // Bitwise invert is 255 - p in every byte lane, no carries.
                dataW = ~dataR;
                if (r_idx == c_LAST_IDX) begin
                    w_state_next = c_DONE;
                end else begin
                    w_idx_next   = r_idx + 16'd1;
                    w_state_next = c_READ;
                end
            end
            c_DONE: begin
                finish = 1'b1;
                // A new job requires start to drop first.
                if (!start) begin
                    w_state_next = c_IDLE;
                    w_idx_next   = '0;
                end
            end
            default: begin
                w_state_next = c_IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_image_invert_accelerator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_image_invert_accelerator
//  Description : Self-checking bench for image_invert_accelerator with a
//                behavioural single-port memory and a pixel-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_image_invert_accelerator;

    localparam int WORDS    = 25344;
    localparam int OUT_BASE = 25344;
    localparam int PIXELS   = WORDS * 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        finish;
    logic        en;
    logic        we;
    logic [15:0] addr;
    logic [31:0] dataW;
    logic [31:0] dataR = '0;

    logic [31:0] mem [0:65535];
    int unsigned wr_cnt [0:65535];
    int unsigned base_cnt [0:65535];
    int          in_wr = 0;
    int          order_bad = 0;
    bit          have_prev = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [15:0] last_wr = '0;
    byte unsigned pix [0:PIXELS-1];

    int total = 0;
    int bad   = 0;

    image_invert_accelerator #(.WORDS(WORDS), .OUT_BASE(OUT_BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .finish (finish),
        .en     (en),
        .we     (we),
        .addr   (addr),
        .dataW  (dataW),
        .dataR  (dataR)
    );

    always #5 clk = ~clk;

    // Single-port memory with registered read, plus write bookkeeping
    always @(posedge clk) begin
        if (en && we) begin
            mem[addr]    <= dataW;
            wr_cnt[addr] <= wr_cnt[addr] + 1;
            if (int'(addr) < OUT_BASE) in_wr <= in_wr + 1;
            if (have_prev && addr <= prev_addr) order_bad <= order_bad + 1;
            prev_addr <= addr;
            have_prev <= 1'b1;
            last_wr   <= addr;
        end
        if (reset || finish) have_prev <= 1'b0;
        if (en && !we) dataR <= mem[addr];
    end

    // Expected result word: each pixel becomes 255 - pixel, little-endian
    function automatic logic [31:0] ref_out_word(input int w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = 8'(255 - int'(pix[4*w + b]));
        return r;
    endfunction

    function automatic logic [31:0] pack_in(input int w);
        return {pix[4*w+3], pix[4*w+2], pix[4*w+1], pix[4*w]};
    endfunction

    task automatic load_image(input bit zeros);
        for (int i = 0; i < PIXELS; i++) pix[i] = zeros ? 8'd0 : 8'($urandom);
        for (int w = 0; w < WORDS; w++) begin
            mem[w]            = pack_in(w);
            mem[OUT_BASE + w] = 32'hA5A5_A5A5;
        end
    endtask

    task automatic snapshot();
        for (int a = 0; a < 65536; a++) base_cnt[a] = wr_cnt[a];
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++; if (en !== 1'b0) begin bad++; $display("FAIL reset_en: got %b want 0", en); end
            total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", we); end
            total++; if (addr !== 16'd0) begin bad++; $display("FAIL reset_addr: got %h want 0", addr); end
            total++; if (dataW !== 32'd0) begin bad++; $display("FAIL reset_dataW: got %h want 0", dataW); end
            total++; if (finish !== 1'b0) begin bad++; $display("FAIL reset_finish: got %b want 0", finish); end
        end
        reset = 1'b0;
    endtask

    task automatic test_two_words();
        pix[0] = 8'h01; pix[1] = 8'h02; pix[2] = 8'h03; pix[3] = 8'h04;
        pix[4] = 8'h80; pix[5] = 8'h7F; pix[6] = 8'hFF; pix[7] = 8'h00;
        mem[0] = pack_in(0);
        mem[1] = pack_in(1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge clk);
            total++;
            if (en !== 1'b1 || we !== 1'b0 || addr !== 16'(k)) begin
                bad++; $display("FAIL two_read%0d: got en=%b we=%b addr=%0d want en=1 we=0 addr=%0d", k, en, we, addr, k);
            end
            @(negedge clk);
            total++;
            if (en !== 1'b1 || we !== 1'b1 || addr !== 16'(OUT_BASE + k) || dataW !== ref_out_word(k)) begin
                bad++; $display("FAIL two_write%0d: got en=%b we=%b addr=%0d data=%h want addr=%0d data=%h",
                                k, en, we, addr, dataW, OUT_BASE + k, ref_out_word(k));
            end
        end
        do_reset();
    endtask

    task automatic test_full_run();
        int n;
        int in_wr0;
        int order0;
        int cnt_bad;
        int pix_bad;
        int in_bad;
        logic [31:0] w;
        load_image(1'b0);
        snapshot();
        in_wr0 = in_wr;
        order0 = order_bad;
        @(negedge clk);
        start = 1'b1;
        n = 0;
        while (finish !== 1'b1 && n < 2*WORDS + 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        total++;
        if (finish !== 1'b1 || n != 2*WORDS + 1) begin
            bad++; $display("FAIL full_latency: got finish=%b after %0d edges want 1 after %0d", finish, n, 2*WORDS + 1);
        end
        total++;
        if (last_wr !== 16'(OUT_BASE + WORDS - 1)) begin
            bad++; $display("FAIL full_last_addr: got %0d want %0d", last_wr, OUT_BASE + WORDS - 1);
        end
        total++;
        if (in_wr != in_wr0) begin
            bad++; $display("FAIL full_input_writes: got %0d want 0", in_wr - in_wr0);
        end
        total++;
        if (order_bad != order0) begin
            bad++; $display("FAIL full_order: got %0d out-of-order writes want 0", order_bad - order0);
        end
        cnt_bad = 0;
        for (int a = OUT_BASE; a < OUT_BASE + WORDS; a++)
            if (wr_cnt[a] - base_cnt[a] != 1) cnt_bad++;
        total++;
        if (cnt_bad != 0) begin
            bad++; $display("FAIL full_write_once: got %0d words not written exactly once want 0", cnt_bad);
        end
        pix_bad = 0;
        for (int i = 0; i < PIXELS; i++) begin
            w = mem[OUT_BASE + i/4];
            if (int'(w[8*(i%4) +: 8]) != 255 - int'(pix[i])) pix_bad++;
        end
        total++;
        if (pix_bad != 0) begin
            bad++; $display("FAIL full_pixels: got %0d wrong pixels want 0", pix_bad);
        end
        in_bad = 0;
        for (int v = 0; v < WORDS; v++) if (mem[v] !== pack_in(v)) in_bad++;
        total++;
        if (in_bad != 0) begin
            bad++; $display("FAIL full_input_kept: got %0d changed words want 0", in_bad);
        end
    endtask

    task automatic test_retrigger();
        // start is still high from the full run
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if (finish !== 1'b1 || en !== 1'b0 || we !== 1'b0) begin
                bad++; $display("FAIL hold_done: got finish=%b en=%b we=%b want 1 0 0", finish, en, we);
            end
        end
        start = 1'b0;
        @(negedge clk);
        total++;
        if (finish !== 1'b0 || en !== 1'b0) begin
            bad++; $display("FAIL drop_start: got finish=%b en=%b want 0 0", finish, en);
        end
        start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            total++;
            if (en !== 1'b1 || we !== 1'b0 || addr !== 16'(k)) begin
                bad++; $display("FAIL rerun_read%0d: got en=%b we=%b addr=%0d want 1 0 %0d", k, en, we, addr, k);
            end
            @(negedge clk);
            total++;
            if (we !== 1'b1 || addr !== 16'(OUT_BASE + k) || dataW !== ref_out_word(k)) begin
                bad++; $display("FAIL rerun_write%0d: got we=%b addr=%0d data=%h want 1 %0d %h",
                                k, we, addr, dataW, OUT_BASE + k, ref_out_word(k));
            end
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        int n;
        int c0;
        load_image(1'b1);
        snapshot();
        c0 = int'(wr_cnt[OUT_BASE + 100]);
        @(negedge clk);
        start = 1'b1;
        n = 0;
        while (!(en === 1'b1 && we === 1'b1 && addr === 16'(OUT_BASE + 100)) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 1000 || dataW !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL mid_reach_idx100: got %0d cycles data=%h want <1000 FFFFFFFF", n, dataW);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (en !== 1'b0 || we !== 1'b0) begin
            bad++; $display("FAIL mid_async_drop: got en=%b we=%b want 0 0", en, we);
        end
        @(negedge clk);
        total++;
        if (int'(wr_cnt[OUT_BASE + 100]) != c0) begin
            bad++; $display("FAIL mid_no_write: got %0d writes to 25444 want 0", int'(wr_cnt[OUT_BASE + 100]) - c0);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (en !== 1'b1 || we !== 1'b0 || addr !== 16'd0) begin
            bad++; $display("FAIL mid_restart_read: got en=%b we=%b addr=%0d want 1 0 0", en, we, addr);
        end
        @(negedge clk);
        total++;
        if (we !== 1'b1 || addr !== 16'(OUT_BASE) || dataW !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL mid_restart_write: got we=%b addr=%0d data=%h want 1 %0d FFFFFFFF", we, addr, dataW, OUT_BASE);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_full_run();
        test_retrigger();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
